// File: rtl/single_port_lutram_arbiter.sv
// single_port_lutram_arbiter
// Shares one single-port LUT RAM between two requesters. After reset every set
// is zero-filled, then commands are granted round-robin over a valid/ready
// handshake. Read data comes back exactly one cycle after the grant.
module single_port_lutram_arbiter #(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
  parameter int NUMBER_SET                = 64,
  parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUMBER_SET)
) (
  input  logic                                 clk_in,
  input  logic                                 reset_in,
  output logic                                 init_done_out,

  input  logic                                 req0_valid_in,
  output logic                                 req0_ready_out,
  input  logic                                 req0_write_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     req0_addr_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] req0_data_in,
  output logic                                 resp0_valid_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] resp0_data_out,

  input  logic                                 req1_valid_in,
  output logic                                 req1_ready_out,
  input  logic                                 req1_write_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     req1_addr_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] req1_data_in,
  output logic                                 resp1_valid_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] resp1_data_out,

  output logic                                 ram_access_en_out,
  output logic                                 ram_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]     ram_addr_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_write_entry_out,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_read_entry_in
);

  localparam int SESB = SINGLE_ENTRY_SIZE_IN_BITS;
  localparam int SPW  = SET_PTR_WIDTH_IN_BITS;
  localparam logic [SPW-1:0] LAST_SET = SPW'(NUMBER_SET - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [SPW-1:0] cnt_q, cnt_d;
  logic           rr_q, rr_d;
  logic           init_done_q, init_done_d;
  logic           pend0_q, pend0_d;
  logic           pend1_q, pend1_d;

  logic gnt0, gnt1, contended;

  // Combinational grant: a lone requester wins, a tie goes to the rr pointer.
  always_comb begin
    contended = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (state_q == ST_ARB) begin
      contended = req0_valid_in & req1_valid_in;
      gnt0      = req0_valid_in & (~req1_valid_in | ~rr_q);
      gnt1      = req1_valid_in & (~req0_valid_in |  rr_q);
    end
  end

  assign req0_ready_out = gnt0;
  assign req1_ready_out = gnt1;

  // RAM control: zero-fill writes during INIT, the winner's command in ARB.
  // Held quiet while reset is asserted even though the state already reads INIT.
  always_comb begin
    ram_access_en_out   = 1'b0;
    ram_write_en_out    = 1'b0;
    ram_addr_out        = '0;
    ram_write_entry_out = '0;
    if (reset_in) begin
      if (state_q == ST_INIT) begin
        ram_access_en_out = 1'b1;
        ram_write_en_out  = 1'b1;
        ram_addr_out      = cnt_q;
      end else if (gnt0) begin
        ram_access_en_out   = 1'b1;
        ram_write_en_out    = req0_write_in;
        ram_addr_out        = req0_addr_in;
        ram_write_entry_out = req0_data_in;
      end else if (gnt1) begin
        ram_access_en_out   = 1'b1;
        ram_write_en_out    = req1_write_in;
        ram_addr_out        = req1_addr_in;
        ram_write_entry_out = req1_data_in;
      end
    end
  end

  // Next-state logic for the fill counter, FSM, rr pointer and read tracking.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    init_done_d = init_done_q;
    pend0_d     = 1'b0;
    pend1_d     = 1'b0;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + SPW'(1);
        if (cnt_q == LAST_SET) begin
          cnt_d       = '0;
          state_d     = ST_ARB;
          init_done_d = 1'b1;
        end
      end
      default: begin
        // Only a contended grant moves the pointer, away from the winner.
        if (contended) begin
          rr_d = ~gnt1;
        end
        pend0_d = gnt0 & ~req0_write_in;
        pend1_d = gnt1 & ~req1_write_in;
      end
    endcase
  end

  // State registers; async reset restarts the fill and drops in-flight reads.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rr_q        <= 1'b0;
      init_done_q <= 1'b0;
      pend0_q     <= 1'b0;
      pend1_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      init_done_q <= init_done_d;
      pend0_q     <= pend0_d;
      pend1_q     <= pend1_d;
    end
  end

  assign init_done_out   = init_done_q;
  assign resp0_valid_out = pend0_q;
  assign resp1_valid_out = pend1_q;
  assign resp0_data_out  = pend0_q ? ram_read_entry_in : {SESB{1'b0}};
  assign resp1_data_out  = pend1_q ? ram_read_entry_in : {SESB{1'b0}};

endmodule

// File: tb/tb_single_port_lutram_arbiter.sv
// Bench for single_port_lutram_arbiter: directed vectors, a behavioural RAM,
// and a response scoreboard drained by an independent monitor process.
module tb_single_port_lutram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        init_done;
  logic        v0, r0, w0, v1, r1, w1;
  logic [5:0]  a0, a1;
  logic [63:0] d0, d1;
  logic        rv0, rv1;
  logic [63:0] rd0, rd1;
  logic        ram_en, ram_we;
  logic [5:0]  ram_addr;
  logic [63:0] ram_wdata, ram_rdata;

  logic [63:0] mem [64];
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];
  int n_vec = 0;
  int n_bad = 0;

  logic [63:0] wtab [3] = '{64'hA5A5_0001_0F0F_1000,
                            64'hA5A5_0002_0F0F_2000,
                            64'hA5A5_0003_0F0F_3000};

  single_port_lutram_arbiter #(
    .SINGLE_ENTRY_SIZE_IN_BITS(64),
    .NUMBER_SET(64)
  ) dut (
    .clk_in(clk), .reset_in(rst_n), .init_done_out(init_done),
    .req0_valid_in(v0), .req0_ready_out(r0), .req0_write_in(w0),
    .req0_addr_in(a0), .req0_data_in(d0),
    .resp0_valid_out(rv0), .resp0_data_out(rd0),
    .req1_valid_in(v1), .req1_ready_out(r1), .req1_write_in(w1),
    .req1_addr_in(a1), .req1_data_in(d1),
    .resp1_valid_out(rv1), .resp1_data_out(rd1),
    .ram_access_en_out(ram_en), .ram_write_en_out(ram_we),
    .ram_addr_out(ram_addr), .ram_write_entry_out(ram_wdata),
    .ram_read_entry_in(ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port RAM with one-cycle registered read.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_check;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("fill_en", {63'd0, ram_en}, 64'd1);
      chk("fill_we", {63'd0, ram_we}, 64'd1);
      chk("fill_addr", {58'd0, ram_addr}, 64'(i));
      chk("fill_data", ram_wdata, 64'd0);
      chk("fill_ready0", {63'd0, r0}, 64'd0);
      chk("fill_done", {63'd0, init_done}, 64'd0);
    end
  endtask

  // Monitor: every presented response must match the head of its queue.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rv0) begin
        if (q0.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL resp0_unexpected: got data %h expected no response", rd0);
        end else begin
          e = q0.pop_front();
          chk("resp0_data", rd0, e);
        end
      end
      if (rv1) begin
        if (q1.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL resp1_unexpected: got data %h expected no response", rd1);
        end else begin
          e = q1.pop_front();
          chk("resp1_data", rd1, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    v0 = 1'b1; w0 = 1'b0; a0 = '0; d0 = '0;
    v1 = 1'b1; w1 = 1'b0; a1 = '0; d1 = '0;

    // Reset state, with both requesters pushing
    repeat (2) tick;
    @(negedge clk);
    chk("rst_done", {63'd0, init_done}, 64'd0);
    chk("rst_en", {63'd0, ram_en}, 64'd0);
    chk("rst_we", {63'd0, ram_we}, 64'd0);
    chk("rst_ready", {62'd0, r1, r0}, 64'd0);
    chk("rst_rvalid", {62'd0, rv1, rv0}, 64'd0);
    chk("rst_rdata", rd0 | rd1, 64'd0);

    // 1: zero-fill after release
    tick;
    v0 = 1'b0; v1 = 1'b0; rst_n = 1'b1;
    fill_check();
    @(negedge clk);
    chk("init_done", {63'd0, init_done}, 64'd1);
    chk("idle_en", {63'd0, ram_en}, 64'd0);

    // 2: read set 5 after init
    tick;
    v0 = 1'b1; w0 = 1'b0; a0 = 6'd5;
    @(negedge clk);
    chk("t2_ready", {62'd0, r1, r0}, 64'd1);
    chk("t2_addr", {58'd0, ram_addr}, 64'd5);
    chk("t2_en_we", {62'd0, ram_en, ram_we}, 64'd2);
    q0.push_back(64'd0);
    tick;
    v0 = 1'b0;
    @(negedge clk);
    chk("t2_idle_en", {63'd0, ram_en}, 64'd0);

    // 3: write set 63 via req0, read back via req1
    tick;
    v0 = 1'b1; w0 = 1'b1; a0 = 6'd63; d0 = 64'hFFFF_FFFF_0000_0000;
    @(negedge clk);
    chk("t3_wready", {62'd0, r1, r0}, 64'd1);
    chk("t3_we", {63'd0, ram_we}, 64'd1);
    chk("t3_waddr", {58'd0, ram_addr}, 64'd63);
    chk("t3_wdata", ram_wdata, 64'hFFFF_FFFF_0000_0000);
    tick;
    v0 = 1'b0; v1 = 1'b1; w1 = 1'b0; a1 = 6'd63;
    @(negedge clk);
    chk("t3_rready", {62'd0, r1, r0}, 64'd2);
    q1.push_back(64'hFFFF_FFFF_0000_0000);
    tick;
    v1 = 1'b0;

    // Seed sets 1 and 2 with distinct data
    v0 = 1'b1; w0 = 1'b1; a0 = 6'd1; d0 = 64'h1111_2222_3333_4444;
    @(negedge clk);
    chk("seed1_ready", {63'd0, r0}, 64'd1);
    tick;
    a0 = 6'd2; d0 = 64'h5555_6666_7777_8888;
    @(negedge clk);
    chk("seed2_ready", {63'd0, r0}, 64'd1);
    tick;

    // 4: both hold reads for 4 cycles -> 0,1,0,1
    v0 = 1'b1; w0 = 1'b0; a0 = 6'd1;
    v1 = 1'b1; w1 = 1'b0; a1 = 6'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        chk("t4_grant0", {62'd0, r1, r0}, 64'd1);
        chk("t4_addr0", {58'd0, ram_addr}, 64'd1);
        q0.push_back(64'h1111_2222_3333_4444);
      end else begin
        chk("t4_grant1", {62'd0, r1, r0}, 64'd2);
        chk("t4_addr1", {58'd0, ram_addr}, 64'd2);
        q1.push_back(64'h5555_6666_7777_8888);
      end
      tick;
    end
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);

    // In-flight read dropped by reset
    tick;
    v0 = 1'b1; w0 = 1'b0; a0 = 6'd1;
    @(negedge clk);
    chk("drop_ready", {63'd0, r0}, 64'd1);
    tick;
    rst_n = 1'b0; v0 = 1'b0;
    #1;
    chk("drop_rvalid", {62'd0, rv1, rv0}, 64'd0);
    chk("drop_rdata", rd0, 64'd0);
    chk("drop_done", {63'd0, init_done}, 64'd0);
    tick;
    rst_n = 1'b1;

    // 5: reset pulse at init cycle 30, full refill with req0 held off
    repeat (30) tick;
    chk("t5_addr30", {58'd0, ram_addr}, 64'd30);
    rst_n = 1'b0;
    #1;
    chk("t5_en", {63'd0, ram_en}, 64'd0);
    chk("t5_we", {63'd0, ram_we}, 64'd0);
    chk("t5_done", {63'd0, init_done}, 64'd0);
    tick;
    rst_n = 1'b1;
    v0 = 1'b1; w0 = 1'b0; a0 = 6'd7;
    fill_check();
    @(negedge clk);
    chk("t5_init_done", {63'd0, init_done}, 64'd1);
    chk("t5_held_grant", {62'd0, r1, r0}, 64'd1);
    chk("t5_held_addr", {58'd0, ram_addr}, 64'd7);
    q0.push_back(64'd0);
    tick;
    v0 = 1'b0;

    // 6: three uncontested req1 writes, then contention -> req0 first
    v1 = 1'b1; w1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a1 = 6'(10 + k); d1 = wtab[k];
      @(negedge clk);
      chk("t6_wgrant", {62'd0, r1, r0}, 64'd2);
      chk("t6_waddr", {58'd0, ram_addr}, 64'(10 + k));
      chk("t6_wdata", ram_wdata, wtab[k]);
      tick;
    end
    w1 = 1'b0; a1 = 6'd12;
    v0 = 1'b1; w0 = 1'b0; a0 = 6'd10;
    @(negedge clk);
    chk("t6_first", {62'd0, r1, r0}, 64'd1);
    chk("t6_first_addr", {58'd0, ram_addr}, 64'd10);
    q0.push_back(wtab[0]);
    tick;
    @(negedge clk);
    chk("t6_second", {62'd0, r1, r0}, 64'd2);
    chk("t6_second_addr", {58'd0, ram_addr}, 64'd12);
    q1.push_back(wtab[2]);
    tick;
    v0 = 1'b0; v1 = 1'b0;

    repeat (3) tick;
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
